// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and helpers for the master slice
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ahb_master_stats.sv
// rtl/ahb_master_stats.sv - saturating transfer and wait-state counters
module ahb_master_stats
    import ahb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        xfer_i,
    input  logic        wait_i,
    output logic [31:0] stat_xfers_o,
    output logic [31:0] stat_waits_o
);

    logic [31:0] xfers_q, xfers_d;
    logic [31:0] waits_q, waits_d;

    always_comb begin
        xfers_d = xfer_i ? sat_inc32(xfers_q) : xfers_q;
        waits_d = wait_i ? sat_inc32(waits_q) : waits_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xfers_q <= 32'd0;
            waits_q <= 32'd0;
        end else begin
            xfers_q <= xfers_d;
            waits_q <= waits_d;
        end
    end

    assign stat_xfers_o = xfers_q;
    assign stat_waits_o = waits_q;

endmodule

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - valid/ready to single-beat AHB-Lite initiator, pipelined address/data phases
// Optional counters: define AHB_MASTER_STATS_EN to add stat_xfers/stat_waits.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
`ifdef AHB_MASTER_STATS_EN
    ,
    output logic [31:0]       stat_xfers,
    output logic [31:0]       stat_waits
`endif
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("ahb_lite_master supports DATA_W == 32 only");
    end

    logic              dp_active_q, dp_active_d;
    logic              dp_write_q, dp_write_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              cancel;
    logic              accept;
    htrans_t           htrans;

    // First cycle of a two-cycle ERROR: the next address phase must not go out.
    assign cancel = dp_active_q && !HREADY && (HRESP == HRESP_ERROR);

    always_comb begin
        htrans = HTRANS_IDLE;
        if (HRESETn && req_valid && !cancel) begin
            htrans = HTRANS_NONSEQ;
        end
    end

    assign accept    = (htrans == HTRANS_NONSEQ) && HREADY;
    assign req_ready = accept;

    assign HTRANS = htrans;
    assign HADDR  = req_addr;
    assign HWRITE = req_write;
    assign HSIZE  = HSIZE_WORD;
    assign HWDATA = hwdata_q;

    // HWDATA only moves on acceptance, which needs HREADY, so it holds across wait states.
    always_comb begin
        dp_active_d = dp_active_q;
        dp_write_d  = dp_write_q;
        hwdata_d    = hwdata_q;
        if (accept) begin
            dp_active_d = 1'b1;
            dp_write_d  = req_write;
            hwdata_d    = req_wdata;
        end else if (HREADY) begin
            dp_active_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_active_q <= 1'b0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= '0;
        end else begin
            dp_active_q <= dp_active_d;
            dp_write_q  <= dp_write_d;
            hwdata_q    <= hwdata_d;
        end
    end

    assign rsp_valid = dp_active_q && HREADY;
    assign rsp_err   = rsp_valid && (HRESP == HRESP_ERROR);
    assign rsp_rdata = (rsp_valid && !dp_write_q) ? HRDATA : '0;

`ifdef AHB_MASTER_STATS_EN
    ahb_master_stats u_stats (
        .clk_i        (HCLK),
        .rst_ni       (HRESETn),
        .xfer_i       (rsp_valid),
        .wait_i       (dp_active_q && !HREADY),
        .stat_xfers_o (stat_xfers),
        .stat_waits_o (stat_waits)
    );
`endif

    a_req_aligned : assert property (@(posedge HCLK) disable iff (!HRESETn)
        req_valid |-> (req_addr[1:0] == 2'b00));

endmodule
